// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [DATA_WIDTH-1:0]       din_i,
  input  logic                        rd_en_i,
  output logic [DATA_WIDTH-1:0]       dout_o,
  output logic                        rd_valid_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_ok, rd_ok;

  // Acceptance is gated by this cycle's flags, so a concurrent pop never frees room for a push.
  assign wr_ok = wr_en_i && !full_q;
  assign rd_ok = rd_en_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
    ovf_d    = wr_en_i && full_q;
    udf_d    = rd_en_i && empty_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr_q] <= din_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout_o     = mem[rd_ptr_q];
  assign rd_valid_o = !empty_q;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    if (rd_ok) begin
      dout_d     = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign dout_o     = dout_q;
  assign rd_valid_o = rd_valid_q;
`endif

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO: the synchronous successor to our dual-clock FIFO, for buffering between I2C byte engines and register/bus logic in one clock domain. It adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and a read-valid strobe. An optional first-word-fall-through read mode is selected at compile time.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read request (pop in FWFT mode)
- dout  out  DATA_WIDTH  read data
- rd_valid  out  1  dout holds newly read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write refused
- underflow  out  1  one-cycle pulse: read refused

## Operation
- Storage: DEPTH × DATA_WIDTH array, not reset. wr_ptr and rd_ptr are AW bits and wrap DEPTH-1 → 0 naturally.
- Write accepted iff wr_en && !full: mem[wr_ptr] ← din, wr_ptr+1.
- Read accepted iff rd_en && !empty: rd_ptr+1.
- count: +1 on write only, −1 on read only, unchanged on both or neither. Full/empty gating uses the current-cycle flags, so a write while full is refused even if a read is accepted in the same cycle. The same applies to a read while empty with a concurrent write.
- full, empty, almost_full and almost_empty are registered and derived from the next value of count. They therefore always agree with count in the same cycle.
- overflow is registered high for one cycle after an edge with wr_en && full. underflow is registered high for one cycle after an edge with rd_en && empty. Neither changes any state.
- Standard read mode (macro absent): on an accepted read, dout ← mem[rd_ptr] and rd_valid ← 1 for one cycle. Otherwise dout holds its value and rd_valid ← 0.

## Timing
- Reset values (asynchronous): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, rd_valid=0, overflow=0, underflow=0. Reset asserted mid-transfer discards all contents immediately.
- Write edge N: count, empty deassert and almost flags update at edge N.
- Standard mode read latency: 1 cycle, rd_en sampled at edge N gives dout/rd_valid valid after edge N.
- Write-to-read throughput: a word written at edge N may be read at edge N+1. Sustained 1 word/cycle when both sides are enabled and 0 < count < DEPTH.
- Wrap-around: pointers wrap silently. count is the sole full/empty arbiter.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - dout = mem[rd_ptr] combinationally whenever !empty.
  - rd_valid = !empty.
  - rd_en acknowledges and pops the head word. The next word is presented after that edge.
  - dout is don't-care while empty.
- SYNC_FIFO_FWFT_EN absent: standard registered read as above.
- Flags, count and error pulses are identical in both modes.

## Test plan
- Reset, then write 0x01..0x10 (DEPTH=16, AF=14, AE=2) → almost_empty drops at count=3; almost_full rises at count=14; full at count=16; a 17th wr_en gives overflow=1 for one cycle with count unchanged at 16.
- From full, read 16 words → dout sequence 0x01..0x10, each with rd_valid; empty=1 after the last read; an extra rd_en gives underflow=1 and dout holds 0x10.
- Simultaneous wr_en/rd_en at count=5 for 40 cycles with an incrementing pattern → count stays 5; data emerges in order across pointer wrap.
- At full, wr_en and rd_en together → read accepted, write refused, overflow=1, count=15.
- Assert rst mid-stream at count=7 → all outputs take reset values at once; a subsequent write/read returns the new word.
- With SYNC_FIFO_FWFT_EN: single write 0xA5 → dout=0xA5 and rd_valid=1 the cycle after the write with no rd_en; rd_en pops it → empty=1, rd_valid=0.
